// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single memory port between an instruction bus (ibus) and a data bus
// (dbus). One transaction is in flight at a time. The winning requester's
// command is captured when the grant is taken, so later changes on its inputs
// cannot disturb the memory cycle. A wait counter aborts a transaction that
// sees mem_waitrequest high for WAIT_TIMEOUT consecutive cycles. An abort
// returns 32'hDEADBEEF to the owner and sets a sticky timeout_err flag.
//
// Parameters
//   WAIT_TIMEOUT     wait cycles tolerated before a transaction is aborted
//
// Build option
//   ARB_ROUND_ROBIN_EN  when defined, a simultaneous request is granted to the
//                       requester that was not served last. When undefined,
//                       dbus always wins a tie.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ibus_* / dbus_*   requester ports: address, byteenable, read, write,
//                     wrdata in; rddata, stall out
//   mem_*             memory port: address, byteenable, read, write, wrdata
//                     out; rddata, waitrequest in
//   busy              high while a grant is held
//   timeout_err       sticky abort flag, cleared only by rst
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_bus_arbiter #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] ibus_address,
  input  logic [3:0]  ibus_byteenable,
  input  logic        ibus_read,
  input  logic        ibus_write,
  input  logic [31:0] ibus_wrdata,
  output logic [31:0] ibus_rddata,
  output logic        ibus_stall,

  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wrdata,
  output logic [31:0] dbus_rddata,
  output logic        dbus_stall,

  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wrdata,
  input  logic [31:0] mem_rddata,
  input  logic        mem_waitrequest,

  output logic        busy,
  output logic        timeout_err
);

  localparam int               CNT_W       = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT);
  localparam logic [31:0]      ABORT_DATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Requests and arbitration
  // ---------------------------------------------------------------------------
  logic req_i, req_d;
  logic prefer_d;
  logic pick_d;

  assign req_i = ibus_read | ibus_write;
  assign req_d = dbus_read | dbus_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Records which requester finished most recently (1 = dbus). A tie goes to
  // the other one, so with reset value ibus the first tie goes to dbus.
  logic last_d_q;
  assign prefer_d = ~last_d_q;
`else
  assign prefer_d = 1'b1;
`endif

  // dbus wins when it requests alone or when it is preferred on a tie.
  assign pick_d = req_d & (~req_i | prefer_d);

  // ---------------------------------------------------------------------------
  // Grant-cycle qualifiers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] wait_cnt_q;
  logic             own_i, own_d, in_grant;
  logic             abort, done, finish;
  logic             keep_i, keep_d;

  assign own_i    = (state_q == GRANT_I);
  assign own_d    = (state_q == GRANT_D);
  assign in_grant = own_i | own_d;

  // rst masks both completion and abort so a transaction interrupted by reset
  // never reports a result; the stalls then simply follow the requests.
  assign abort  = in_grant & ~rst & (wait_cnt_q == TIMEOUT_CNT);
  assign done   = in_grant & ~rst & ~mem_waitrequest & ~abort;
  assign finish = abort | done;

  // The owner still wants its result only while it keeps requesting; if it
  // has dropped the request the memory cycle runs to the end and is discarded.
  assign keep_i = own_i & req_i;
  assign keep_d = own_d & req_d;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default on the first
  // line, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d)     state_d = GRANT_D;
        else if (req_i) state_d = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so rst is tested inside the clocked block and
  // clk is the only event in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command capture: the winner's fields are latched on the IDLE->GRANT edge
  // and drive the memory port for the whole grant. They keep their value in
  // IDLE, which is why mem_address/byteenable/wrdata hold between grants.
  // ---------------------------------------------------------------------------
  logic [31:0] sel_address, sel_wrdata;
  logic [3:0]  sel_byteenable;
  logic        sel_read, sel_write;
  logic        load;

  assign sel_address    = pick_d ? dbus_address    : ibus_address;
  assign sel_byteenable = pick_d ? dbus_byteenable : ibus_byteenable;
  assign sel_wrdata     = pick_d ? dbus_wrdata     : ibus_wrdata;
  assign sel_read       = pick_d ? dbus_read       : ibus_read;
  assign sel_write      = pick_d ? dbus_write      : ibus_write;

  assign load = (state_q == IDLE) & (req_i | req_d);

  logic [31:0] addr_q, wrdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      be_q     <= '0;
      wrdata_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else if (load) begin
      addr_q   <= sel_address;
      be_q     <= sel_byteenable;
      wrdata_q <= sel_wrdata;
      // Read and write together is treated as a write.
      rd_q     <= sel_read & ~sel_write;
      wr_q     <= sel_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait counter: zero in IDLE, so it is clear on every grant entry. It stops
  // at TIMEOUT_CNT; the abort that follows returns the FSM to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !in_grant) begin
      wait_cnt_q <= '0;
    end else if (mem_waitrequest && !abort) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read data holding registers and status
  // ---------------------------------------------------------------------------
  logic [31:0] rddata_i_q, rddata_d_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rddata_i_q <= '0;
      rddata_d_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (keep_i && done)       rddata_i_q <= mem_rddata;
      else if (keep_i && abort) rddata_i_q <= ABORT_DATA;

      if (keep_d && done)       rddata_d_q <= mem_rddata;
      else if (keep_d && abort) rddata_d_q <= ABORT_DATA;

      if (abort) err_q <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (finish) begin
      last_d_q <= own_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // In the completion/abort cycle the result passes straight through; at all
  // other times the last delivered value is held.
  assign ibus_rddata = (keep_i & done)  ? mem_rddata :
                       (keep_i & abort) ? ABORT_DATA : rddata_i_q;
  assign dbus_rddata = (keep_d & done)  ? mem_rddata :
                       (keep_d & abort) ? ABORT_DATA : rddata_d_q;

  // A requester is released only in its own completion or abort cycle.
  assign ibus_stall = req_i & ~(own_i & finish);
  assign dbus_stall = req_d & ~(own_d & finish);

  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_wrdata     = wrdata_q;
  assign mem_read       = in_grant & rd_q;
  assign mem_write      = in_grant & wr_q;

  assign busy        = in_grant;
  // Visible already in the abort cycle, then held by err_q until reset.
  assign timeout_err = err_q | abort;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios for the documented corner cases, followed by a randomized
// run. In the randomized run, two bus agents and a random-latency memory are
// compared with a transaction-level model: one owner at a time, a grant decided
// from the pending requests, and a fixed number of memory waits per
// transaction.
// Inputs are driven 1 ns after the rising edge and outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

  localparam int TO = 8;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_address, ibus_wrdata, ibus_rddata;
  logic [3:0]  ibus_byteenable;
  logic        ibus_read, ibus_write, ibus_stall;
  logic [31:0] dbus_address, dbus_wrdata, dbus_rddata;
  logic [3:0]  dbus_byteenable;
  logic        dbus_read, dbus_write, dbus_stall;
  logic [31:0] mem_address, mem_wrdata, mem_rddata;
  logic [3:0]  mem_byteenable;
  logic        mem_read, mem_write, mem_waitrequest;
  logic        busy, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .ibus_address    (ibus_address),
    .ibus_byteenable (ibus_byteenable),
    .ibus_read       (ibus_read),
    .ibus_write      (ibus_write),
    .ibus_wrdata     (ibus_wrdata),
    .ibus_rddata     (ibus_rddata),
    .ibus_stall      (ibus_stall),
    .dbus_address    (dbus_address),
    .dbus_byteenable (dbus_byteenable),
    .dbus_read       (dbus_read),
    .dbus_write      (dbus_write),
    .dbus_wrdata     (dbus_wrdata),
    .dbus_rddata     (dbus_rddata),
    .dbus_stall      (dbus_stall),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wrdata      (mem_wrdata),
    .mem_rddata      (mem_rddata),
    .mem_waitrequest (mem_waitrequest),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ibus_address = '0; ibus_byteenable = '0; ibus_read = 1'b0; ibus_write = 1'b0; ibus_wrdata = '0;
    dbus_address = '0; dbus_byteenable = '0; dbus_read = 1'b0; dbus_write = 1'b0; dbus_wrdata = '0;
    mem_rddata = '0; mem_waitrequest = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    n_tests++;
    if ({mem_read, mem_write, busy, timeout_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got rd/wr/busy/err=%b want 0000", {mem_read, mem_write, busy, timeout_err});
    end
    n_tests++;
    if ({mem_address, mem_byteenable, mem_wrdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_mem_fields: got %h want 0", {mem_address, mem_byteenable, mem_wrdata});
    end
    n_tests++;
    if ({ibus_rddata, dbus_rddata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rddata: got %h want 0", {ibus_rddata, dbus_rddata});
    end
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ibus_read();
    next_cycle();
    ibus_address = 32'h8000_0000; ibus_read = 1'b1;
    mem_waitrequest = 1'b0; mem_rddata = 32'h3C01_0001;
    settle();
    n_tests++;
    if ({ibus_stall, mem_read, busy} !== 3'b100) begin
      n_fail++; $display("FAIL ird_req_cycle: got stall/mrd/busy=%b want 100", {ibus_stall, mem_read, busy});
    end
    next_cycle();
    settle();
    n_tests++;
    if ({mem_read, mem_write, ibus_stall} !== 3'b100) begin
      n_fail++; $display("FAIL ird_cmd_cycle: got mrd/mwr/stall=%b want 100", {mem_read, mem_write, ibus_stall});
    end
    n_tests++;
    if (mem_address !== 32'h8000_0000) begin
      n_fail++; $display("FAIL ird_addr: got %h want 80000000", mem_address);
    end
    n_tests++;
    if (ibus_rddata !== 32'h3C01_0001) begin
      n_fail++; $display("FAIL ird_data: got %h want 3c010001", ibus_rddata);
    end
    next_cycle();
    ibus_read = 1'b0; mem_rddata = 32'h1111_2222;
    settle();
    n_tests++;
    if ({busy, mem_read, ibus_rddata, mem_address} !== {2'b00, 32'h3C01_0001, 32'h8000_0000}) begin
      n_fail++; $display("FAIL ird_idle_hold: got %h want %h", {busy, mem_read, ibus_rddata, mem_address},
                         {2'b00, 32'h3C01_0001, 32'h8000_0000});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drop_req();
    next_cycle();
    ibus_address = 32'h8000_0100; ibus_read = 1'b1; mem_waitrequest = 1'b1;
    settle();
    next_cycle();
    ibus_read = 1'b0; ibus_address = 32'h0;
    settle();
    n_tests++;
    if ({mem_read, busy, ibus_stall, mem_address} !== {3'b110, 32'h8000_0100}) begin
      n_fail++; $display("FAIL drop_grant1: got %h want %h", {mem_read, busy, ibus_stall, mem_address}, {3'b110, 32'h8000_0100});
    end
    next_cycle();
    settle();
    n_tests++;
    if ({mem_read, busy} !== 2'b11) begin
      n_fail++; $display("FAIL drop_grant2: got mrd/busy=%b want 11", {mem_read, busy});
    end
    next_cycle();
    mem_waitrequest = 1'b0; mem_rddata = 32'hBAD0_0001;
    settle();
    n_tests++;
    if ({mem_read, ibus_rddata} !== {1'b1, 32'h3C01_0001}) begin
      n_fail++; $display("FAIL drop_complete: got mrd/rddata=%h want 13c010001", {mem_read, ibus_rddata});
    end
    next_cycle();
    settle();
    n_tests++;
    if ({busy, ibus_rddata} !== {1'b0, 32'h3C01_0001}) begin
      n_fail++; $display("FAIL drop_discard: got busy/rddata=%h want 03c010001", {busy, ibus_rddata});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Both requesters raise in the same cycle. Two rounds give order D, I, D, I
  // under either arbitration mode, because ibus is always the last one served.
  task automatic test_simultaneous();
    logic [31:0] iaddr;
    for (int r = 0; r < 2; r++) begin
      iaddr = 32'h8000_0040 + 32'(r * 4);
      next_cycle();
      ibus_address = iaddr; ibus_read = 1'b1;
      dbus_address = 32'h8000_1000; dbus_wrdata = 32'h1234_5678; dbus_byteenable = 4'b0011; dbus_write = 1'b1;
      mem_waitrequest = 1'b0;
      settle();
      n_tests++;
      if ({ibus_stall, dbus_stall, busy} !== 3'b110) begin
        n_fail++; $display("FAIL sim_req r%0d: got is/ds/busy=%b want 110", r, {ibus_stall, dbus_stall, busy});
      end
      next_cycle();
      settle();
      n_tests++;
      if ({mem_read, mem_write, mem_address, mem_byteenable, mem_wrdata} !==
          {2'b01, 32'h8000_1000, 4'b0011, 32'h1234_5678}) begin
        n_fail++; $display("FAIL sim_dcmd r%0d: got %h want %h", r, {mem_read, mem_write, mem_address, mem_byteenable, mem_wrdata},
                           {2'b01, 32'h8000_1000, 4'b0011, 32'h1234_5678});
      end
      n_tests++;
      if ({ibus_stall, dbus_stall} !== 2'b10) begin
        n_fail++; $display("FAIL sim_dgrant_stall r%0d: got is/ds=%b want 10", r, {ibus_stall, dbus_stall});
      end
      next_cycle();
      dbus_write = 1'b0;
      settle();
      n_tests++;
      if ({busy, mem_read, mem_write, ibus_stall} !== 4'b0001) begin
        n_fail++; $display("FAIL sim_bubble r%0d: got busy/mrd/mwr/is=%b want 0001", r, {busy, mem_read, mem_write, ibus_stall});
      end
      next_cycle();
      settle();
      n_tests++;
      if ({mem_read, mem_write, ibus_stall, mem_address} !== {3'b100, iaddr}) begin
        n_fail++; $display("FAIL sim_icmd r%0d: got %h want %h", r, {mem_read, mem_write, ibus_stall, mem_address}, {3'b100, iaddr});
      end
      next_cycle();
      ibus_read = 1'b0;
      settle();
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL sim_end r%0d: got busy=%b want 0", r, busy);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wait_hold();
    next_cycle();
    dbus_address = 32'h0000_2000; dbus_read = 1'b1; mem_waitrequest = 1'b1;
    settle();
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 2) dbus_address = 32'hFFFF_0000;
      if (c == 4) begin mem_waitrequest = 1'b0; mem_rddata = 32'hA5A5_1234; end
      settle();
      n_tests++;
      if ({mem_read, mem_address} !== {1'b1, 32'h0000_2000}) begin
        n_fail++; $display("FAIL wait_addr c%0d: got %h want 100002000", c, {mem_read, mem_address});
      end
      n_tests++;
      if (dbus_stall !== (c != 4)) begin
        n_fail++; $display("FAIL wait_stall c%0d: got %b want %b", c, dbus_stall, (c != 4));
      end
    end
    n_tests++;
    if (dbus_rddata !== 32'hA5A5_1234) begin
      n_fail++; $display("FAIL wait_data: got %h want a5a51234", dbus_rddata);
    end
    next_cycle();
    dbus_read = 1'b0;
    settle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    next_cycle();
    ibus_address = 32'h8000_0200; ibus_read = 1'b1; mem_waitrequest = 1'b0;
    settle();
    next_cycle();
    settle();
    n_tests++;
    if ({ibus_stall, mem_address} !== {1'b0, 32'h8000_0200}) begin
      n_fail++; $display("FAIL b2b_first: got %h want 080000200", {ibus_stall, mem_address});
    end
    next_cycle();
    ibus_address = 32'h8000_0204;
    settle();
    n_tests++;
    if ({busy, mem_read, ibus_stall} !== 3'b001) begin
      n_fail++; $display("FAIL b2b_bubble: got busy/mrd/stall=%b want 001", {busy, mem_read, ibus_stall});
    end
    next_cycle();
    settle();
    n_tests++;
    if ({mem_read, ibus_stall, mem_address} !== {2'b10, 32'h8000_0204}) begin
      n_fail++; $display("FAIL b2b_second: got %h want %h", {mem_read, ibus_stall, mem_address}, {2'b10, 32'h8000_0204});
    end
    next_cycle();
    ibus_read = 1'b0;
    settle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    next_cycle();
    dbus_address = 32'h8000_4000; dbus_read = 1'b1; mem_waitrequest = 1'b1;
    settle();
    for (int k = 1; k <= TO + 1; k++) begin
      next_cycle();
      settle();
      n_tests++;
      if (k <= TO) begin
        if ({dbus_stall, timeout_err, busy} !== 3'b101) begin
          n_fail++; $display("FAIL to_wait k%0d: got stall/err/busy=%b want 101", k, {dbus_stall, timeout_err, busy});
        end
      end else begin
        if ({dbus_stall, timeout_err, dbus_rddata} !== {2'b01, 32'hDEAD_BEEF}) begin
          n_fail++; $display("FAIL to_abort: got %h want 1deadbeef", {dbus_stall, timeout_err, dbus_rddata});
        end
      end
    end
    next_cycle();
    dbus_read = 1'b0; mem_waitrequest = 1'b0;
    settle();
    n_tests++;
    if ({busy, timeout_err, dbus_rddata} !== {2'b01, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL to_after: got %h want 1deadbeef", {busy, timeout_err, dbus_rddata});
    end
    next_cycle();
    ibus_address = 32'h8000_0300; ibus_read = 1'b1;
    settle();
    next_cycle();
    settle();
    n_tests++;
    if ({ibus_stall, timeout_err} !== 2'b01) begin
      n_fail++; $display("FAIL to_sticky: got stall/err=%b want 01", {ibus_stall, timeout_err});
    end
    next_cycle();
    ibus_read = 1'b0;
    settle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_grant();
    next_cycle();
    dbus_address = 32'h8000_3000; dbus_read = 1'b1; mem_waitrequest = 1'b1;
    settle();
    next_cycle();
    settle();
    n_tests++;
    if ({busy, mem_read} !== 2'b11) begin
      n_fail++; $display("FAIL rstg_grant: got busy/mrd=%b want 11", {busy, mem_read});
    end
    next_cycle();
    rst = 1'b1; mem_waitrequest = 1'b0; mem_rddata = 32'h7777_0000;
    settle();
    n_tests++;
    if ({dbus_stall, dbus_rddata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rstg_no_complete: got stall/rddata=%h want 1deadbeef", {dbus_stall, dbus_rddata});
    end
    next_cycle();
    rst = 1'b0; dbus_read = 1'b0;
    settle();
    n_tests++;
    if ({busy, mem_read, mem_write, timeout_err, dbus_stall, dbus_rddata} !== 37'h0) begin
      n_fail++; $display("FAIL rstg_idle: got %h want 0", {busy, mem_read, mem_write, timeout_err, dbus_stall, dbus_rddata});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized traffic. Starts from the post-reset state left by the previous
  // test: held data 0, memory fields 0, ibus counted as last served.
  task automatic test_random();
    cmd_t        cmd [2];
    cmd_t        granted;
    logic        active [2];
    logic [31:0] exp_rd [2];
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_be;
    logic [69:0] exp_mem;
    logic        complete, prefer_d;
    logic        exp_stall_i, exp_stall_d;
    logic [31:0] exp_data_i, exp_data_d;
    int          owner, waits_left, last_served;
    int          served [2];

    owner = -1; waits_left = 0; last_served = 0;
    hold_addr = '0; hold_wdata = '0; hold_be = '0;
    for (int r = 0; r < 2; r++) begin
      active[r] = 1'b0; exp_rd[r] = '0; served[r] = 0;
      cmd[r].addr = '0; cmd[r].be = '0; cmd[r].wdata = '0; cmd[r].rd = 1'b0; cmd[r].wr = 1'b0;
    end
    granted = cmd[0];

    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cycle();
      for (int r = 0; r < 2; r++) begin
        if (!active[r] && $urandom_range(0, 2) == 0) begin
          active[r] = 1'b1;
          cmd[r].addr = $urandom; cmd[r].be = 4'($urandom); cmd[r].wdata = $urandom;
          case ($urandom_range(0, 2))
            0:       begin cmd[r].rd = 1'b1; cmd[r].wr = 1'b0; end
            1:       begin cmd[r].rd = 1'b0; cmd[r].wr = 1'b1; end
            default: begin cmd[r].rd = 1'b1; cmd[r].wr = 1'b1; end
          endcase
        end
      end
      // Once granted, an agent scrambles its address/data inputs; only the
      // captured command may reach memory.
      ibus_read       = active[0] & cmd[0].rd;
      ibus_write      = active[0] & cmd[0].wr;
      ibus_address    = (owner == 0 || !active[0]) ? $urandom         : cmd[0].addr;
      ibus_byteenable = (owner == 0 || !active[0]) ? 4'($urandom)     : cmd[0].be;
      ibus_wrdata     = (owner == 0 || !active[0]) ? $urandom         : cmd[0].wdata;
      dbus_read       = active[1] & cmd[1].rd;
      dbus_write      = active[1] & cmd[1].wr;
      dbus_address    = (owner == 1 || !active[1]) ? $urandom         : cmd[1].addr;
      dbus_byteenable = (owner == 1 || !active[1]) ? 4'($urandom)     : cmd[1].be;
      dbus_wrdata     = (owner == 1 || !active[1]) ? $urandom         : cmd[1].wdata;
      mem_waitrequest = (owner >= 0) ? (waits_left > 0) : 1'($urandom);
      mem_rddata      = $urandom;
      settle();

      complete = (owner >= 0) && (waits_left == 0);
      if (owner >= 0) exp_mem = {granted.rd & ~granted.wr, granted.wr, granted.addr, granted.be, granted.wdata};
      else            exp_mem = {2'b00, hold_addr, hold_be, hold_wdata};
      exp_stall_i = active[0] & ~(complete && owner == 0);
      exp_stall_d = active[1] & ~(complete && owner == 1);
      exp_data_i  = (complete && owner == 0) ? mem_rddata : exp_rd[0];
      exp_data_d  = (complete && owner == 1) ? mem_rddata : exp_rd[1];

      n_tests++;
      if ({busy, timeout_err} !== {(owner >= 0), 1'b0}) begin
        n_fail++; $display("FAIL rand_status cyc%0d: got busy/err=%b want %b", cyc, {busy, timeout_err}, {(owner >= 0), 1'b0});
      end
      n_tests++;
      if ({mem_read, mem_write, mem_address, mem_byteenable, mem_wrdata} !== exp_mem) begin
        n_fail++; $display("FAIL rand_mem cyc%0d: got %h want %h", cyc,
                           {mem_read, mem_write, mem_address, mem_byteenable, mem_wrdata}, exp_mem);
      end
      n_tests++;
      if ({ibus_stall, dbus_stall} !== {exp_stall_i, exp_stall_d}) begin
        n_fail++; $display("FAIL rand_stall cyc%0d: got is/ds=%b want %b", cyc, {ibus_stall, dbus_stall}, {exp_stall_i, exp_stall_d});
      end
      n_tests++;
      if ({ibus_rddata, dbus_rddata} !== {exp_data_i, exp_data_d}) begin
        n_fail++; $display("FAIL rand_rddata cyc%0d: got %h want %h", cyc, {ibus_rddata, dbus_rddata}, {exp_data_i, exp_data_d});
      end

      // Advance the model across the clock edge.
      if (owner >= 0) begin
        if (complete) begin
          exp_rd[owner] = mem_rddata;
          active[owner] = 1'b0;
          served[owner]++;
          last_served = owner;
          owner = -1;
        end else begin
          waits_left--;
        end
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        prefer_d = (last_served == 0);
`else
        prefer_d = 1'b1;
`endif
        if (active[1] && (!active[0] || prefer_d)) owner = 1;
        else if (active[0])                        owner = 0;
        if (owner >= 0) begin
          granted    = cmd[owner];
          hold_addr  = granted.addr;
          hold_be    = granted.be;
          hold_wdata = granted.wdata;
          waits_left = $urandom_range(0, 3);
        end
      end
    end

    n_tests++;
    if (served[0] == 0 || served[1] == 0) begin
      n_fail++; $display("FAIL rand_progress: got served i=%0d d=%0d want both nonzero", served[0], served[1]);
    end
    next_cycle();
    clear_inputs();
    settle();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ibus_read();
    test_drop_req();
    test_simultaneous();
    test_wait_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
